// File: rtl/clock_meter_pkg.sv
// Shared definitions for the clock period meter: FSM encoding and lock/sync constants.
package clock_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_FAULT   = 2'd3
  } meter_state_e;

  // Two periods within this many cycles of each other count as a match.
  localparam int LOCK_TOL        = 1;
  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level plus single-cycle rise/fall strobes.
// Reusable for any slow asynchronous input (buttons, divided clocks).
module sync_edge_detect
  import clock_meter_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // Requests below the metastability minimum are quietly raised to it.
  localparam int N = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

  logic [N-1:0] sync_q;
  logic         prev_q;

  // NOTE: non-blocking assignments so each stage captures its neighbour's pre-edge value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[N-2:0], din};
      prev_q <= sync_q[N-1];
    end
  end

  assign level = sync_q[N-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous clock in system-clock cycles,
// and reports lock (stable period) and timeout (clock stopped).
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int CNT_WIDTH      = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_COUNT     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 in_clock,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 period_valid,
  output logic                 locked,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] TMO     = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH:0]   TOL     = (CNT_WIDTH+1)'(LOCK_TOL);
  localparam logic [3:0]           LOCK_N  = 4'(LOCK_COUNT);

  logic level_unused, rise, fall;

  sync_edge_detect #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .din  (in_clock),
    .level(level_unused),
    .rise (rise),
    .fall (fall)
  );

  meter_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_WIDTH-1:0] prev_period_q, prev_period_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_q, high_d;
  logic [3:0]           match_q, match_d, match_upd;
  logic                 first_q, first_d;
  logic                 pv_q, pv_d;
  logic                 locked_q, locked_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH:0]   diff;

  // Extra bit keeps the absolute difference exact for any pair of counts.
  always_comb begin
    if (cnt_q >= prev_period_q) diff = {1'b0, cnt_q} - {1'b0, prev_period_q};
    else                        diff = {1'b0, prev_period_q} - {1'b0, cnt_q};
    if (first_q)            match_upd = '0;
    else if (diff <= TOL)   match_upd = (match_q == LOCK_N) ? match_q : match_q + 4'd1;
    else                    match_upd = '0;
  end

  // NOTE: every _d takes its _q value first, so no path through this block infers a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hi_lat_d      = hi_lat_q;
    prev_period_d = prev_period_q;
    period_d      = period_q;
    high_d        = high_q;
    match_d       = match_q;
    first_d       = first_q;
    pv_d          = 1'b0;
    locked_d      = locked_q;
    timeout_d     = timeout_q;

    if (!enable) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      match_d   = '0;
      locked_d  = 1'b0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d   = '0;
          match_d = '0;
          state_d = ST_ARM;
        end
        ST_ARM, ST_FAULT: begin
          if (rise) begin
            state_d = ST_MEASURE;
            cnt_d   = CNT_ONE;
            first_d = 1'b1;
          end else if (state_q == ST_ARM) begin
            if (cnt_q >= TMO) begin
              state_d   = ST_FAULT;
              timeout_d = 1'b1;
              locked_d  = 1'b0;
              match_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        ST_MEASURE: begin
          if (fall) hi_lat_d = cnt_q;
          if (rise) begin
            period_d      = cnt_q;
            high_d        = hi_lat_q;
            pv_d          = 1'b1;
            timeout_d     = 1'b0;
            cnt_d         = CNT_ONE;
            first_d       = 1'b0;
            prev_period_d = cnt_q;
            match_d       = match_upd;
            locked_d      = (match_upd == LOCK_N);
          end else if (cnt_q >= TMO) begin
            state_d   = ST_FAULT;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            match_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      hi_lat_q      <= '0;
      prev_period_q <= '0;
      period_q      <= '0;
      high_q        <= '0;
      match_q       <= '0;
      first_q       <= 1'b0;
      pv_q          <= 1'b0;
      locked_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hi_lat_q      <= hi_lat_d;
      prev_period_q <= prev_period_d;
      period_q      <= period_d;
      high_q        <= high_d;
      match_q       <= match_d;
      first_q       <= first_d;
      pv_q          <= pv_d;
      locked_q      <= locked_d;
      timeout_q     <= timeout_d;
    end
  end

  assign period       = period_q;
  assign high_time    = high_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: expected measurements are queued when each
// in_clock rise is driven and compared when period_valid appears.
module tb_clock_period_meter;

  localparam int CNT_WIDTH  = 16;
  localparam int LOCK_COUNT = 4;
  localparam int TMO        = 100;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 in_clock;
  logic [CNT_WIDTH-1:0] period;
  logic [CNT_WIDTH-1:0] high_time;
  logic                 period_valid;
  logic                 locked;
  logic                 timeout;

  clock_period_meter #(
    .CNT_WIDTH     (CNT_WIDTH),
    .SYNC_STAGES   (2),
    .LOCK_COUNT    (LOCK_COUNT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .in_clock    (in_clock),
    .period      (period),
    .high_time   (high_time),
    .period_valid(period_valid),
    .locked      (locked),
    .timeout     (timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    int p;
    int h;
    bit lk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_valid = 0;
  int   cyc = 0;
  int   last_valid_cyc = 0;

  // Reference model of the measurement/lock behaviour.
  bit m_meas = 0;
  bit m_first = 0;
  int m_prev = 0;
  int m_match = 0;
  int m_last_p = 0;
  int m_last_h = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_rise();
    int d;
    if (!m_meas) begin
      m_meas  = 1;
      m_first = 1;
    end else begin
      if (m_first) begin
        m_match = 0;
        m_first = 0;
      end else begin
        d = (m_last_p > m_prev) ? m_last_p - m_prev : m_prev - m_last_p;
        if (d <= 1) m_match = (m_match >= LOCK_COUNT) ? LOCK_COUNT : m_match + 1;
        else        m_match = 0;
      end
      m_prev = m_last_p;
      sb.push_back('{m_last_p, m_last_h, (m_match == LOCK_COUNT)});
    end
  endtask

  // One in_clock period of p cycles with h cycles high, starting at a falling clock edge.
  task automatic drive_period(input int p, input int h);
    model_rise();
    in_clock = 1'b1;
    repeat (h) @(negedge clock);
    in_clock = 1'b0;
    repeat (p - h) @(negedge clock);
    m_last_p = p;
    m_last_h = h;
  endtask

  always @(negedge clock) begin
    if (!reset && period_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
      check("valid_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("period", period, mon_e.p);
        check("high_time", high_time, mon_e.h);
        check("locked_on_valid", locked, mon_e.lk);
        check("timeout_on_valid", timeout, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int vc;
    reset    = 1'b1;
    enable   = 1'b1;
    in_clock = 1'b0;

    // Reset held while in_clock toggles.
    repeat (2) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      in_clock = ~in_clock;
      @(negedge clock);
      check("rst_period", period, 0);
      check("rst_high_time", high_time, 0);
      check("rst_flags", {period_valid, locked, timeout}, 0);
    end
    in_clock = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Divide-by-2 input.
    for (int i = 0; i < 8; i++) drive_period(2, 1);

    // Period 10, tolerated drift to 11, disruptive change to 14, back to 10.
    for (int i = 0; i < 6; i++) drive_period(10, 3);
    for (int i = 0; i < 3; i++) drive_period(11, 3);
    for (int i = 0; i < 6; i++) drive_period(14, 5);
    for (int i = 0; i < 6; i++) drive_period(10, 3);

    // Stall the input low and wait for the timeout.
    repeat (3) @(negedge clock);
    check("locked_before_stall", locked, 1);
    k = 0;
    while (!timeout && k < 300) begin
      @(negedge clock);
      k++;
    end
    check("timeout_seen", timeout, 1);
    check("timeout_latency", cyc - last_valid_cyc, TMO);
    check("locked_after_timeout", locked, 0);
    check("period_hold_fault", period, 10);
    m_meas = 0;

    // Resume at period 10; timeout clears with the first new measurement.
    drive_period(10, 3);
    check("timeout_held_until_valid", timeout, 1);
    for (int i = 0; i < 5; i++) drive_period(10, 3);
    check("locked_after_resume", locked, 1);

    // Enable dropped mid-measurement.
    @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    check("dis_locked", locked, 0);
    check("dis_timeout", timeout, 0);
    check("dis_period_hold", period, 10);
    check("dis_high_hold", high_time, 3);
    repeat (5) @(negedge clock);
    enable = 1'b1;
    m_meas = 0;
    repeat (2) @(negedge clock);
    vc = n_valid;
    drive_period(6, 2);
    check("no_valid_after_first_rise", n_valid, vc);
    for (int i = 0; i < 3; i++) drive_period(6, 2);

    // Asynchronous reset between clock edges.
    check("sb_empty_pre_reset", sb.size(), 0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_period", period, 0);
    check("async_rst_high_time", high_time, 0);
    check("async_rst_flags", {period_valid, locked, timeout}, 0);
    #1 reset = 1'b0;
    m_meas = 0;
    @(negedge clock);
    for (int i = 0; i < 3; i++) drive_period(6, 2);
    repeat (4) @(negedge clock);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clock_period_meter.md
Name: clock_period_meter

Overview:
- Receiving end of the clock-divider outputs: samples a slow, divider-generated clock (in_clock) in the fast system clock domain.
- Measures its period and high time in system-clock cycles.
- Flags lock when consecutive periods agree, and flags timeout when in_clock stops toggling.
- Used to self-check divider chains on the board and to feed period readouts to display logic.

Parameters:
- CNT_WIDTH, 16, width of period/high-time counters and outputs.
- SYNC_STAGES, 2, synchroniser flops on in_clock (minimum 2).
- LOCK_COUNT, 4, consecutive matching periods required to assert locked (1..15).
- TIMEOUT_CYCLES, 65535, cycles without a rising edge before timeout (2..2^CNT_WIDTH-1).

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- enable  input  1  measurement enable; 0 forces IDLE.
- in_clock  input  1  slow clock under test; asynchronous to clock.
- period  output  CNT_WIDTH  last measured period, in clock cycles.
- high_time  output  CNT_WIDTH  high-phase length of that period, in clock cycles.
- period_valid  output  1  one-cycle pulse when period/high_time update.
- locked  output  1  period stable.
- timeout  output  1  no rising edge within TIMEOUT_CYCLES.

Behaviour:
- Reset (async): all flops cleared. period=0, high_time=0, period_valid=0, locked=0, timeout=0, state=IDLE.
- Synchroniser and edge detect:
  - in_clock passes through SYNC_STAGES flops (reset 0), then one history flop.
  - rise = s & ~prev; fall = ~s & prev.
  - Edge-to-detect latency: SYNC_STAGES+1 clock edges.
- FSM states:
  - IDLE: cnt=0, match_cnt=0. enable=1 -> ARM.
  - ARM: cnt increments. rise -> MEASURE with cnt<=1; no output update. cnt reaching TIMEOUT_CYCLES -> FAULT.
  - MEASURE:
    - cnt increments every cycle.
    - On fall: hi_lat <= cnt.
    - On rise: period <= cnt; high_time <= hi_lat; period_valid=1 for one cycle; timeout <= 0; cnt <= 1.
    - cnt reaching TIMEOUT_CYCLES with no rise that cycle -> FAULT, timeout<=1, locked<=0, match_cnt<=0.
  - FAULT: cnt frozen; timeout held at 1. rise -> MEASURE with cnt<=1; the next period_valid clears timeout.
  - Any state with enable=0 -> IDLE next cycle: locked<=0, timeout<=0; period/high_time hold their last values.
- Lock tracking, evaluated on each period_valid:
  - First measurement after ARM/FAULT: match_cnt=0, stored as prev_period.
  - Afterwards: |cnt - prev_period| <= 1 -> match_cnt++ (saturating at LOCK_COUNT); otherwise match_cnt=0.
  - locked is registered alongside period_valid as (new match_cnt == LOCK_COUNT).
- Simultaneous events:
  - rise and timeout threshold in the same cycle: rise wins.
  - rise and fall cannot coincide.
  - enable=0 overrides everything except reset.
- Width rules:
  - cnt never wraps; it is bounded by TIMEOUT_CYCLES.
  - Difference compare uses CNT_WIDTH+1 bits.
  - Minimum measurable period: 2 cycles.
- Reset mid-operation: outputs drop to 0 without waiting for a clock edge; a pending period_valid is lost.

Decomposition:
- Package clock_meter_pkg holds:
  - state encoding IDLE/ARM/MEASURE/FAULT (2-bit);
  - LOCK_TOL=1;
  - minimum SYNC_STAGES constant.
- Sub-module sync_edge_detect (parameter STAGES; ports clock, reset, din, level, rise, fall) holds the synchroniser plus edge logic. It is reusable for button inputs elsewhere.

Test Plan:
1. Reset held with in_clock toggling, enable=1 -> all outputs 0 throughout; release reset -> first period_valid only after two in_clock rises.
2. in_clock toggling every clock cycle (divide-by-2 of clock), enable=1 -> period_valid every 2 cycles with period=2, high_time=1; locked rises on the 5th valid and stays 1.
3. in_clock period 10, high 3 -> period=10, high_time=3, locked after 5 valids. Change to period 11 -> locked stays 1. Change to period 14 -> locked=0 on that valid, then re-locks 4 valids later.
4. TIMEOUT_CYCLES=100, in_clock stuck low after lock -> timeout=1 and locked=0 exactly 100 cycles after the last detected rise. Resume at period 10 -> timeout clears on the first period_valid.
5. enable deasserted mid-MEASURE -> IDLE next cycle, locked=0, period/high_time unchanged. Re-enable -> no period_valid until second rise.
6. Async reset pulse between clock edges during MEASURE -> period, high_time, locked, timeout all 0 before the next clock edge.
